// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one external request/acknowledge bus
// between instruction fetch (IF) and the data-memory stage (MEM).
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   if_req/if_addr       fetch request (level) and address
//   if_flush             branch flush, discards in-flight fetch result
//   if_ready/if_rdata    one-cycle fetch completion pulse, instruction
//   dm_rd_ctrl/wr_ctrl   load/store type (0 = none)
//   dm_addr/dm_wdata     data address and store data
//   data_ready/dm_rdata  one-cycle data completion pulse, load data
//   bus_req/we/ctrl      bus transaction valid, write, access type
//   bus_addr/bus_wdata   registered bus address and write data
//   bus_ack/bus_rdata    bus completion and read data
//   bus_err              one-cycle watchdog timeout pulse
//
// Optional: define ARB_TIMEOUT_EN to enable the BUSY watchdog
// (TIMEOUT_CYCLES); otherwise bus_err is tied low and the
// arbiter waits indefinitely for bus_ack.

module mem_port_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int INST_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [INST_W-1:0] if_rdata,
    input  logic [2:0]        dm_rd_ctrl,
    input  logic [2:0]        dm_wr_ctrl,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              data_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [2:0]        bus_ctrl,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err
);

    typedef enum logic [2:0] {
        IDLE,
        D_BUSY,
        D_DONE,
        I_BUSY,
        I_DONE
    } state_t;

    state_t state, state_n;

    logic dm_any;
    logic start_d, start_i;
    logic d_ack, i_ack;
    logic d_to, i_to;
    logic to_hit;
    logic discard;

    assign dm_any = (dm_rd_ctrl != 3'b000) || (dm_wr_ctrl != 3'b000);

    always_comb begin
        state_n = state;
        start_d = 1'b0;
        start_i = 1'b0;
        d_ack   = 1'b0;
        i_ack   = 1'b0;
        d_to    = 1'b0;
        i_to    = 1'b0;
        unique case (state)
            IDLE: begin
                // Data first: the MEM-stage instruction is older.
                if (dm_any) begin
                    state_n = D_BUSY;
                    start_d = 1'b1;
                end else if (if_req) begin
                    state_n = I_BUSY;
                    start_i = 1'b1;
                end
            end
            D_BUSY: begin
                if (bus_ack) begin
                    state_n = D_DONE;
                    d_ack   = 1'b1;
                end else if (to_hit) begin
                    state_n = D_DONE;
                    d_to    = 1'b1;
                end
            end
            I_BUSY: begin
                if (bus_ack) begin
                    state_n = I_DONE;
                    i_ack   = 1'b1;
                end else if (to_hit) begin
                    state_n = I_DONE;
                    i_to    = 1'b1;
                end
            end
            D_DONE:  state_n = IDLE;
            I_DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus_req    = (state == D_BUSY) || (state == I_BUSY);
    assign data_ready = (state == D_DONE);
    // A flush in the completion cycle kills the result as well.
    assign if_ready   = (state == I_DONE) && !discard && !if_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bus_we    <= 1'b0;
            bus_ctrl  <= 3'b000;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            discard   <= 1'b0;
        end else begin
            state <= state_n;
            if (start_d) begin
                bus_addr  <= dm_addr;
                bus_wdata <= dm_wdata;
                // Both ctrl set is illegal; the write wins.
                bus_we    <= (dm_wr_ctrl != 3'b000);
                bus_ctrl  <= (dm_wr_ctrl != 3'b000) ? dm_wr_ctrl
                                                    : dm_rd_ctrl;
            end
            if (start_i) begin
                bus_addr <= if_addr;
                bus_we   <= 1'b0;
                bus_ctrl <= 3'b010;
            end
            if (d_ack && !bus_we) begin
                dm_rdata <= bus_rdata;
            end
            if (d_to) begin
                dm_rdata <= '0;
            end
            if (i_ack) begin
                if_rdata <= bus_rdata[INST_W-1:0];
            end
            if (i_to) begin
                if_rdata <= '0;
            end
            // The bus cannot abort, so a flushed fetch runs to
            // completion and its result is dropped in I_DONE.
            if (state == I_DONE) begin
                discard <= 1'b0;
            end else if ((start_i || state == I_BUSY) && if_flush) begin
                discard <= 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    // Fires in the last allowed BUSY cycle so that exactly
    // TIMEOUT_CYCLES BUSY cycles are spent before giving up.
    assign to_hit  = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= d_to || i_to;
            if (start_d || start_i) begin
                wd_cnt <= '0;
            end else if (bus_req && !bus_ack) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
`else
    assign to_hit  = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (TIMEOUT_CYCLES > 0)
                else $error("TIMEOUT_CYCLES must be positive");
            if (start_d) begin
                assert (!(dm_rd_ctrl != 3'b000 && dm_wr_ctrl != 3'b000))
                    else $error("load and store ctrl both set");
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, directed
// corner sequences and a random run against a transaction model.

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_flush;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic [2:0]  dm_rd_ctrl;
    logic [2:0]  dm_wr_ctrl;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        data_ready;
    logic [63:0] dm_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [2:0]  bus_ctrl;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic        bus_ack;
    logic [63:0] bus_rdata;
    logic        bus_err;

    int n_chk = 0;
    int n_fail = 0;

    mem_port_arbiter #(
        .ADDR_W(64), .DATA_W(64), .INST_W(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_rd_ctrl(dm_rd_ctrl), .dm_wr_ctrl(dm_wr_ctrl),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .data_ready(data_ready), .dm_rdata(dm_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_ctrl(bus_ctrl),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_f;
        logic [2:0]  rd;
        logic [2:0]  wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          waits;
        logic [63:0] rdata;
        logic        exp_we;
        logic [2:0]  exp_ctrl;
        logic [63:0] exp_out;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; if_flush = 0;
        dm_rd_ctrl = 0; dm_wr_ctrl = 0; dm_addr = 0; dm_wdata = 0;
        bus_ack = 0; bus_rdata = 0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string s;
        s = $sformatf("v%0d", idx);
        cyc();
        if (v.is_f) begin
            if_req = 1; if_addr = v.addr;
        end else begin
            dm_rd_ctrl = v.rd; dm_wr_ctrl = v.wr;
            dm_addr = v.addr; dm_wdata = v.wdata;
        end
        // stray ack while idle must be ignored
        bus_ack = 1; bus_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        smp();
        chk({s, "_idle_req"}, bus_req, 0);
        for (int w = 0; w <= v.waits; w++) begin
            cyc();
            bus_ack = (w == v.waits);
            bus_rdata = (w == v.waits) ? v.rdata : 64'hBAD1_BAD1_BAD1_BAD1;
            smp();
            chk({s, "_bus_req"}, bus_req, 1);
            chk({s, "_bus_addr"}, bus_addr, v.addr);
            chk({s, "_bus_we"}, bus_we, v.exp_we);
            chk({s, "_bus_ctrl"}, bus_ctrl, v.exp_ctrl);
            if (v.exp_we) chk({s, "_bus_wdata"}, bus_wdata, v.wdata);
            chk({s, "_early_dr"}, data_ready, 0);
            chk({s, "_early_ir"}, if_ready, 0);
        end
        cyc();
        bus_ack = 0;
        smp();
        chk({s, "_bus_req_off"}, bus_req, 0);
        chk({s, "_data_ready"}, data_ready, !v.is_f);
        chk({s, "_if_ready"}, if_ready, v.is_f);
        if (v.is_f) chk({s, "_if_rdata"}, if_rdata, v.exp_out);
        else        chk({s, "_dm_rdata"}, dm_rdata, v.exp_out);
        chk({s, "_bus_err"}, bus_err, 0);
        cyc();
        idle_inputs();
        smp();
        chk({s, "_after_dr"}, data_ready, 0);
        chk({s, "_after_ir"}, if_ready, 0);
    endtask

    // random-run model state
    bit          t_valid, t_isf, t_disc, t_we, done_disc, exp_req, exp_ifr;
    logic [2:0]  t_ctrl;
    logic [63:0] t_addr, t_wdata;
    int          t_start, avail, done_kind, new_done;
    logic [63:0] m_dm;
    logic [31:0] m_if;
    bit          d_on, f_on;
    logic [2:0]  d_rd, d_wr;
    logic [63:0] d_addr, d_wdata, f_addr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{0, 3'd5, 3'd0, 64'h0, 64'h0, 0,
                  64'h0, 1'b0, 3'd5, 64'h0};
        vt[1] = '{0, 3'd3, 3'd0, 64'h1000, 64'h0, 0,
                  64'hDEADBEEF_CAFEF00D, 1'b0, 3'd3, 64'hDEADBEEF_CAFEF00D};
        vt[2] = '{0, 3'd0, 3'd3, 64'h2008, 64'h55, 2,
                  64'h7777_7777_7777_7777, 1'b1, 3'd3, 64'hDEADBEEF_CAFEF00D};
        vt[3] = '{0, 3'd1, 3'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1,
                  64'h0123456789ABCDEF, 1'b0, 3'd1, 64'h0123456789ABCDEF};
        vt[4] = '{1, 3'd0, 3'd0, 64'h80, 64'h0, 0,
                  64'hAAAA_BBBB_1234_5678, 1'b0, 3'd2, 64'h1234_5678};
        vt[5] = '{1, 3'd0, 3'd0, 64'h84, 64'h0, 3,
                  64'hFFFF_FFFF_0000_0013, 1'b0, 3'd2, 64'h13};

        idle_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        smp();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_ctrl", bus_ctrl, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_data_ready", data_ready, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_bus_err", bus_err, 0);

        for (int i = 0; i < 6; i++) run_vec(vt[i], i);

        // reset in the middle of a data transaction
        cyc();
        dm_rd_ctrl = 3'd3; dm_addr = 64'h5000;
        smp();
        cyc();
        smp();
        chk("midrst_busy", bus_req, 1);
        cyc();
        rst_n = 0;
        cyc();
        cyc();
        rst_n = 1;
        idle_inputs();
        smp();
        chk("midrst_bus_req", bus_req, 0);
        chk("midrst_data_ready", data_ready, 0);
        chk("midrst_if_ready", if_ready, 0);
        chk("midrst_dm_rdata", dm_rdata, 0);
        chk("midrst_if_rdata", if_rdata, 0);
        chk("midrst_bus_addr", bus_addr, 0);

        // fetch and store requested together: store first
        cyc();
        if_req = 1; if_addr = 64'h80;
        dm_wr_ctrl = 3'd3; dm_addr = 64'h3000; dm_wdata = 64'h55;
        smp();
        chk("cont_idle", bus_req, 0);
        cyc();
        bus_ack = 1;
        smp();
        chk("cont_st_req", bus_req, 1);
        chk("cont_st_we", bus_we, 1);
        chk("cont_st_addr", bus_addr, 64'h3000);
        chk("cont_st_wdata", bus_wdata, 64'h55);
        chk("cont_st_ctrl", bus_ctrl, 3'd3);
        cyc();
        bus_ack = 0;
        smp();
        chk("cont_data_ready", data_ready, 1);
        chk("cont_no_if_ready", if_ready, 0);
        cyc();
        dm_wr_ctrl = 0;
        smp();
        chk("cont_gap", bus_req, 0);
        cyc();
        bus_ack = 1; bus_rdata = 64'h1111_2222_0000_0017;
        smp();
        chk("cont_if_req", bus_req, 1);
        chk("cont_if_addr", bus_addr, 64'h80);
        chk("cont_if_we", bus_we, 0);
        chk("cont_if_ctrl", bus_ctrl, 3'd2);
        cyc();
        bus_ack = 0;
        smp();
        chk("cont_if_ready", if_ready, 1);
        chk("cont_if_rdata", if_rdata, 64'h17);
        chk("cont_if_no_dr", data_ready, 0);
        cyc();
        idle_inputs();
        smp();

        // flush while the fetch is waiting on the bus
        cyc();
        if_req = 1; if_addr = 64'h100;
        smp();
        chk("fl_idle_ir", if_ready, 0);
        for (int b = 1; b <= 4; b++) begin
            cyc();
            if_flush = (b == 2);
            bus_ack = (b == 4);
            bus_rdata = (b == 4) ? 64'hCCCC_CCCC_CCCC_CCCC : 64'h0;
            smp();
            chk("fl_bus_req", bus_req, 1);
            chk("fl_bus_addr", bus_addr, 64'h100);
            chk("fl_busy_ir", if_ready, 0);
        end
        cyc();
        bus_ack = 0; if_flush = 0; if_addr = 64'h200;
        smp();
        chk("fl_done_ir", if_ready, 0);
        chk("fl_done_req", bus_req, 0);
        cyc();
        smp();
        chk("fl_idle2", bus_req, 0);
        cyc();
        bus_ack = 1; bus_rdata = 64'h9999_9999_0000_0033;
        smp();
        chk("fl2_bus_req", bus_req, 1);
        chk("fl2_bus_addr", bus_addr, 64'h200);
        cyc();
        bus_ack = 0;
        smp();
        chk("fl2_if_ready", if_ready, 1);
        chk("fl2_if_rdata", if_rdata, 64'h33);
        cyc();
        idle_inputs();
        smp();

`ifdef ARB_TIMEOUT_EN
        cyc();
        dm_rd_ctrl = 3'd3; dm_addr = 64'h4000;
        smp();
        for (int b = 1; b <= 4; b++) begin
            cyc();
            smp();
            chk("to_busy_req", bus_req, 1);
            chk("to_busy_err", bus_err, 0);
        end
        cyc();
        smp();
        chk("to_req_drop", bus_req, 0);
        chk("to_bus_err", bus_err, 1);
        chk("to_data_ready", data_ready, 1);
        chk("to_dm_rdata", dm_rdata, 0);
        cyc();
        dm_rd_ctrl = 0; bus_ack = 1; bus_rdata = '1;
        smp();
        chk("to_err_once", bus_err, 0);
        chk("to_dr_once", data_ready, 0);
        chk("to_late_req", bus_req, 0);
        cyc();
        bus_ack = 0;
        smp();
        chk("to_late_rdata", dm_rdata, 0);
        chk("to_late_req2", bus_req, 0);
`endif

        // random run against a transaction-level model
        t_valid = 0; t_isf = 0; t_disc = 0; t_we = 0; t_ctrl = 0;
        t_addr = 0; t_wdata = 0; t_start = 0; avail = 0;
        done_kind = 0; done_disc = 0;
        m_dm = 0; m_if = 0;
        d_on = 0; f_on = 0; d_rd = 0; d_wr = 0;
        d_addr = 0; d_wdata = 0; f_addr = 0;
        for (int k = 0; k < 3000; k++) begin
            cyc();
            exp_req = t_valid && (k >= t_start);
            if_req = f_on; if_addr = f_addr;
            dm_rd_ctrl = d_on ? d_rd : 3'd0;
            dm_wr_ctrl = d_on ? d_wr : 3'd0;
            dm_addr = d_addr; dm_wdata = d_wdata;
            if_flush = ($urandom_range(0, 7) == 0);
            if (exp_req)
                bus_ack = ((k - t_start) >= 2) || ($urandom_range(0, 1) == 1);
            else
                bus_ack = ($urandom_range(0, 3) == 0);
            bus_rdata = {$urandom, $urandom};
            smp();

            chk("rnd_bus_req", bus_req, exp_req);
            if (exp_req) begin
                chk("rnd_bus_addr", bus_addr, t_addr);
                chk("rnd_bus_we", bus_we, t_we);
                chk("rnd_bus_ctrl", bus_ctrl, t_ctrl);
                if (t_we) chk("rnd_bus_wdata", bus_wdata, t_wdata);
            end
            chk("rnd_data_ready", data_ready, done_kind == 1);
            if (done_kind == 1) chk("rnd_dm_rdata", dm_rdata, m_dm);
            exp_ifr = (done_kind == 2) && !done_disc && !if_flush;
            chk("rnd_if_ready", if_ready, exp_ifr);
            if (exp_ifr) chk("rnd_if_rdata", if_rdata, m_if);
            chk("rnd_bus_err", bus_err, 0);

            new_done = 0;
            if (exp_req && bus_ack) begin
                new_done = t_isf ? 2 : 1;
                done_disc = t_disc || (t_isf && if_flush);
                if (t_isf) m_if = bus_rdata[31:0];
                else if (!t_we) m_dm = bus_rdata;
                t_valid = 0;
                avail = k + 2;
            end else if (exp_req && t_isf && if_flush) begin
                t_disc = 1;
            end
            if (!t_valid && k >= avail &&
                (dm_rd_ctrl != 0 || dm_wr_ctrl != 0 || if_req)) begin
                t_valid = 1;
                t_start = k + 1;
                if (dm_rd_ctrl != 0 || dm_wr_ctrl != 0) begin
                    t_isf = 0;
                    t_we = (dm_wr_ctrl != 0);
                    t_ctrl = t_we ? dm_wr_ctrl : dm_rd_ctrl;
                    t_addr = dm_addr;
                    t_wdata = dm_wdata;
                    t_disc = 0;
                end else begin
                    t_isf = 1;
                    t_we = 0;
                    t_ctrl = 3'd2;
                    t_addr = if_addr;
                    t_disc = if_flush;
                end
            end

            if (done_kind == 1) d_on = 0;
            if (exp_ifr) f_on = 0;
            if (if_flush) f_addr = {$urandom, $urandom} & ~64'h3;
            if (!d_on && $urandom_range(0, 3) == 0) begin
                d_on = 1;
                if ($urandom_range(0, 1) == 1) begin
                    d_rd = 3'($urandom_range(1, 7)); d_wr = 0;
                end else begin
                    d_wr = 3'($urandom_range(1, 7)); d_rd = 0;
                end
                d_addr = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom};
            end
            if (!f_on && $urandom_range(0, 2) == 0) begin
                f_on = 1;
                f_addr = {$urandom, $urandom} & ~64'h3;
            end
            done_kind = new_done;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory bus between instruction fetch (IF) and the data-memory stage (MEM) of the pipeline.
- Sequences each access as a bus request/acknowledge transaction.
- Returns results with one-cycle completion pulses: `if_ready` for fetch, `data_ready` for data.
- `data_ready` feeds the hazard unit, which stalls the pipeline while a data access is pending.

Parameters:
- ADDR_W, 64, address width on all ports.
- DATA_W, 64, data-access width and bus data width.
- INST_W, 32, instruction width returned to IF (low INST_W bits of `bus_rdata`).
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request, level; held by IF until `if_ready`
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  branch-taken flush; discards the in-flight fetch result
- if_ready  out  1  one-cycle pulse: `if_rdata` valid
- if_rdata  out  INST_W  registered instruction
- dm_rd_ctrl  in  3  load type, 0 = no load
- dm_wr_ctrl  in  3  store type, 0 = no store
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- data_ready  out  1  one-cycle pulse: data access complete, `dm_rdata` valid for loads
- dm_rdata  out  DATA_W  registered load data
- bus_req  out  1  bus transaction valid
- bus_we  out  1  1 = write
- bus_ctrl  out  3  access size/type, copied from `dm_rd_ctrl`/`dm_wr_ctrl`; 3'b010 for fetch
- bus_addr  out  ADDR_W  registered address
- bus_wdata  out  DATA_W  registered write data
- bus_ack  in  1  bus completes the current transaction this cycle
- bus_rdata  in  DATA_W  read data, valid with `bus_ack`
- bus_err  out  1  one-cycle timeout pulse; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- States: IDLE, D_BUSY, D_DONE, I_BUSY, I_DONE.
- Reset (rst_n=0 at a clock edge), taking effect from any state including mid-transaction:
  - state is IDLE;
  - `bus_req`, `bus_we`, `bus_err`, `if_ready`, `data_ready` are 0;
  - `bus_ctrl`, `bus_addr`, `bus_wdata`, `if_rdata`, `dm_rdata` are 0;
  - the discard flag and the watchdog counter are cleared.
- IDLE:
  - A data request (`dm_rd_ctrl` != 0 or `dm_wr_ctrl` != 0) goes to D_BUSY.
  - Otherwise `if_req` goes to I_BUSY.
  - Data has fixed priority over fetch (the older instruction wins).
- On entry to a BUSY state, `bus_addr`, `bus_wdata`, `bus_ctrl` and `bus_we` are latched. They stay stable until `bus_ack`, whatever the inputs do.
- `bus_req` = 1 exactly while in D_BUSY or I_BUSY.
- If both read and write ctrl are nonzero, the access is a write (`bus_we`=1, `bus_ctrl`=`dm_wr_ctrl`). This case is illegal and flagged by a simulation assertion.
- D_BUSY:
  - On `bus_ack`, latch `bus_rdata` into `dm_rdata` (reads only; unchanged on writes) and go to D_DONE.
  - With no `bus_ack`, hold.
- D_DONE: `data_ready` = 1 for this cycle only, then IDLE. The pipeline advances on this edge; a new ctrl value seen in IDLE next cycle starts a new access.
- I_BUSY:
  - On `bus_ack`, latch `bus_rdata[INST_W-1:0]` into `if_rdata` and go to I_DONE.
  - If `if_flush` is seen in I_BUSY, or in the same cycle as entry, set a discard flag. The transaction still completes on the bus, since it cannot be aborted.
- I_DONE: `if_ready` = 1 unless the discard flag is set; clear the flag; go to IDLE.
- `if_flush` in I_DONE suppresses `if_ready` in that cycle.
- Latency with zero bus wait: request seen in cycle 0 → `bus_req` in cycle 1 with `bus_ack` in cycle 1 → done pulse in cycle 2. Each bus wait cycle adds one cycle.
- `bus_ack` outside a BUSY state is ignored (no state or output change).
- Back-to-back: no IDLE bubble is skipped. Each transaction occupies at least BUSY + DONE + IDLE, so peak throughput is one access per 3 cycles.
- `data_ready` = 0 in every state except D_DONE. `if_ready` = 0 in every state except I_DONE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider counter clears on BUSY entry and increments each BUSY cycle without `bus_ack`.
  - When it reaches TIMEOUT_CYCLES, the block leaves BUSY for the matching DONE state with `dm_rdata`/`if_rdata` = 0 and pulses `bus_err` for 1 cycle, coincident with the transition edge's following cycle.
  - A late `bus_ack` arriving after the timeout is ignored.
- When undefined: no counter, `bus_err` tied 0, and the block waits indefinitely for `bus_ack`.

Test Plan:
- Reset then idle:
  - Stimulus: `rst_n`=0 for 2 cycles while in D_BUSY with `bus_req`=1; release.
  - Response: `bus_req`=0, `data_ready`=0, `if_ready`=0, `dm_rdata`=0 on the first cycle after reset.
- Zero-wait load:
  - Stimulus: `dm_rd_ctrl`=3'b011, `dm_addr`=0x1000; `bus_ack`=1 with `bus_rdata`=0xDEADBEEF_CAFEF00D in the first `bus_req` cycle.
  - Response: `data_ready` pulses exactly in cycle 2 with `dm_rdata`=0xDEADBEEF_CAFEF00D; `bus_we`=0; `bus_addr`=0x1000.
- Contention:
  - Stimulus: `if_req`=1 at 0x80 and a store (`dm_wr_ctrl`=3'b011, `dm_wdata`=0x55) both asserted in cycle 0.
  - Response: the store is granted first (`bus_we`=1, `bus_addr`=`dm_addr`), `data_ready` pulses, then the fetch issues with `bus_addr`=0x80 and `if_ready` pulses.
- Flush during fetch:
  - Stimulus: fetch at 0x100 with 3 wait cycles; `if_flush`=1 in the second BUSY cycle.
  - Response: the bus transaction completes; `if_ready` stays 0 throughout; the next `if_req` at 0x200 returns normally.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: load with `bus_ack` held 0.
  - Response: `bus_req` drops after 4 BUSY cycles; `bus_err`=1 and `data_ready`=1 for one cycle with `dm_rdata`=0; a later `bus_ack` is ignored.
